change_logger: RTL and testbench
================================

CHANGE_LOGGER -- requirements
Module: change_logger

Interface
REQ-001 Parameter DEPTH, default 8, meaning event FIFO depth in records (power of two, 2..64).
REQ-002 Parameter TS_W, default 16, meaning timestamp counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 a, b, c  input  1 each  monitored stimulus signals, sampled every cycle.
REQ-006 d, e  input  1 each  monitored response signals, sampled every cycle.
REQ-007 rec_data  output  TS_W+7  head record: {ts, chg_d, chg_e, d, e, a, b, c}, ts in MSBs, c in LSB.
REQ-008 rec_valid  output  1  FIFO non-empty; rec_data is valid.
REQ-009 rec_ready  input  1  consumer accepts head record when rec_valid & rec_ready.
REQ-010 count  output  $clog2(DEPTH)+1  number of records currently stored.
REQ-011 overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-012 Timestamp counter ts SHALL increment by 1 every cycle out of reset, wrapping from 2^TS_W-1 to 0.
REQ-013 Block SHALL register d and e each cycle into d_q, e_q (previous-sample registers).
REQ-014 Event SHALL be detected in a cycle when d != d_q or e != e_q.
REQ-015 First cycle after reset SHALL NOT detect an event (d_q, e_q are loaded with current d, e; prime flag).
REQ-016 On event, record SHALL hold the current ts, chg_d = (d != d_q), chg_e = (e != e_q), and current d, e, a, b, c.
REQ-017 Simultaneous change of d and e SHALL produce one record with chg_d = chg_e = 1.
REQ-018 Record SHALL be written to the FIFO tail on the same rising edge that the event is detected; rec_valid asserted the following cycle (latency 1).
REQ-019 rec_data, rec_valid SHALL be driven from registered state only (no combinational path from a..e or rec_ready).
REQ-020 Pop SHALL occur on a rising edge with rec_valid & rec_ready; next record appears the following cycle.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 Full (count == DEPTH) and event without pop in the same cycle: record SHALL be dropped, FIFO unchanged, overflow set.
REQ-023 Full with simultaneous event and pop: pop and write SHALL both occur, count stays DEPTH, no overflow.
REQ-024 Empty with simultaneous event and rec_ready high: no pop (rec_valid low); write occurs, count becomes 1.
REQ-025 Non-empty, non-full, simultaneous push and pop: count unchanged.
REQ-026 overflow SHALL stay set until reset.
REQ-027 rec_ready while rec_valid low SHALL have no effect.

Reset
REQ-028 While reset high: ts = 0, count = 0, rec_valid = 0, overflow = 0, pointers = 0, prime flag cleared.
REQ-029 rec_data SHALL be 0 during reset and whenever rec_valid is low.
REQ-030 Reset asserted mid-operation SHALL discard all stored records on that edge; consumer sees rec_valid = 0 next cycle.
REQ-031 Events coinciding with reset-high cycles SHALL NOT be recorded.

Verification
REQ-032 Reset 2 cycles, d=e=0, then d rises at ts=5 with a,b,c=1,0,1 -> one record {ts=5, chg_d=1, chg_e=0, d=1, e=0, a=1, b=0, c=1}, rec_valid high from ts=6.
REQ-033 d and e toggle together at ts=10 -> single record with chg_d=chg_e=1, count increments by exactly 1.
REQ-034 rec_ready=0, d toggles every cycle for 10 cycles (DEPTH=8) -> count=8, overflow=1, stored ts values are first 8 event times in order.
REQ-035 FIFO full, rec_ready=1, d toggles each cycle -> count stays 8, overflow stays 0, popped ts values strictly consecutive.
REQ-036 Reset asserted with count=5 -> next cycle count=0, rec_valid=0, overflow=0, ts=0; d held constant across reset release produces no record.
REQ-037 Run 2^TS_W+3 cycles with an event at the final cycle -> recorded ts = 2 (wrap verified).

Source files
------------

// File: rtl/change_logger.sv
// Change logger: timestamps every change on the response signals d/e together
// with the stimulus snapshot a/b/c, and queues the records in a small FIFO.
module change_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a,
  input  logic                     b,
  input  logic                     c,
  input  logic                     d,
  input  logic                     e,
  output logic [TS_W+6:0]          rec_data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 7;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts;
  logic            d_q;
  logic            e_q;
  logic            primed;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            chg_d;
  logic            chg_e;
  logic            evt;
  logic            full;
  logic            pop;
  logic            push;
  logic [RW-1:0]   rec_new;

  always_comb begin
    chg_d   = d ^ d_q;
    chg_e   = e ^ e_q;
    // the first cycle after reset only loads the previous-sample registers
    evt     = ~reset & primed & (chg_d | chg_e);
    full    = (count == CNT_FULL);
    pop     = rec_valid & rec_ready;
    push    = evt & (~full | pop);
    rec_new = {ts, chg_d, chg_e, d, e, a, b, c};
  end

  assign rec_valid = (count != '0);
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts       <= '0;
      d_q      <= d;
      e_q      <= e;
      primed   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      ts     <= ts + 1'b1;
      d_q    <= d;
      e_q    <= e;
      primed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // a pop in the same cycle frees the slot, so only a non-popping full FIFO drops
      if (evt & full & ~pop) overflow <= 1'b1;
    end
  end

  // storage is not reset; rec_data is gated by rec_valid instead
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_new;
  end

endmodule

// File: tb/tb_change_logger.sv
// Scoreboard bench for change_logger: a bench-side model queues expected
// records as stimulus is applied and compares them as the DUT pops them.
module tb_change_logger;
  localparam int DEPTH = 8;
  localparam int TS_W  = 8;
  localparam int RW    = TS_W + 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic          rec_ready = 1'b0;
  logic [RW-1:0] rec_data;
  logic          rec_valid;
  logic [3:0]    count;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  logic [RW-1:0]   sb[$];
  logic [TS_W-1:0] popped[$];
  logic [TS_W-1:0] m_ts = '0;
  logic            m_dq = 1'b0, m_eq = 1'b0, m_primed = 1'b0, m_ovf = 1'b0;
  logic [TS_W-1:0] t0;

  change_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d), .e(e),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock: update the model from the driven inputs, then check outputs.
  task automatic step();
    logic            mevt;
    logic            mpop;
    logic            mfull;
    logic [RW-1:0]   exp_rec;
    if (reset) begin
      m_ts = '0;
      sb.delete();
      m_ovf = 1'b0;
      m_primed = 1'b0;
    end else begin
      mevt  = m_primed && ((d != m_dq) || (e != m_eq));
      mfull = (sb.size() == DEPTH);
      mpop  = (sb.size() != 0) && rec_ready;
      if (mpop) begin
        exp_rec = sb.pop_front();
        chk("pop_data", 32'(rec_data), 32'(exp_rec));
        popped.push_back(rec_data[RW-1:7]);
      end
      if (mevt) begin
        if (!mfull || mpop)
          sb.push_back({m_ts, d != m_dq, e != m_eq, d, e, a, b, c});
        else
          m_ovf = 1'b1;
      end
      m_ts = m_ts + 1'b1;
      m_primed = 1'b1;
    end
    m_dq = d;
    m_eq = e;
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(sb.size()));
    chk("valid", 32'(rec_valid), 32'(sb.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("head", 32'(rec_data), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
  endtask

  task automatic toggle_d(input int n);
    for (int i = 0; i < n; i++) begin
      d = ~d;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; a = 1'b1; b = 1'b0; c = 1'b1;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_data", 32'(rec_data), 32'd0);
    reset = 1'b0;

    // single change of d at ts=5
    while (m_ts != 8'd5) step();
    d = 1'b1;
    step();
    chk("r32_valid", 32'(rec_valid), 32'd1);
    chk("r32_rec", 32'(rec_data), 32'({8'd5, 7'b1010101}));
    rec_ready = 1'b1; step(); rec_ready = 1'b0;

    // simultaneous d/e change at ts=10
    while (m_ts != 8'd10) step();
    d = 1'b0; e = 1'b1;
    step();
    chk("r33_count", 32'(count), 32'd1);
    chk("r33_rec", 32'(rec_data), 32'({8'd10, 7'b1101101}));
    rec_ready = 1'b1; step(); rec_ready = 1'b0;

    // overflow: 10 events, no consumer
    t0 = m_ts;
    toggle_d(10);
    chk("r34_count", 32'(count), 32'd8);
    chk("r34_ovf", 32'(overflow), 32'd1);
    popped.delete();
    rec_ready = 1'b1;
    repeat (8) step();
    rec_ready = 1'b0;
    chk("r34_npop", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++)
      chk("r34_ts", 32'(popped[i]), 32'(TS_W'(t0 + i)));

    // full FIFO with push and pop every cycle
    reset = 1'b1; step(); step(); reset = 1'b0;
    step();
    t0 = m_ts;
    toggle_d(8);
    chk("r35_full", 32'(count), 32'd8);
    chk("r35_ovf0", 32'(overflow), 32'd0);
    popped.delete();
    rec_ready = 1'b1;
    repeat (10) begin
      d = ~d;
      step();
      chk("r35_count", 32'(count), 32'd8);
      chk("r35_ovf", 32'(overflow), 32'd0);
    end
    rec_ready = 1'b0;
    chk("r35_npop", 32'(popped.size()), 32'd10);
    for (int i = 0; i < popped.size(); i++)
      chk("r35_ts", 32'(popped[i]), 32'(TS_W'(t0 + i)));

    // reset mid-operation with count=5 and overflow set
    toggle_d(2);
    rec_ready = 1'b1;
    repeat (3) step();
    rec_ready = 1'b0;
    chk("r36_pre_count", 32'(count), 32'd5);
    chk("r36_pre_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    d = ~d;
    step();
    chk("r36_count", 32'(count), 32'd0);
    chk("r36_valid", 32'(rec_valid), 32'd0);
    chk("r36_ovf", 32'(overflow), 32'd0);
    step();
    reset = 1'b0;

    // timestamp wrap; consumer ready while empty
    rec_ready = 1'b1;
    for (int k = 0; k < 258; k++) begin
      step();
      if (k == 2) chk("r36_norec", 32'(count), 32'd0);
    end
    d = ~d;
    step();
    chk("r37_count", 32'(count), 32'd1);
    chk("r37_ts", 32'(rec_data[RW-1:7]), 32'd2);
    step();
    chk("r37_popped", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
